uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Serial program loader that sits directly upstream of the CPU core in `cpu_uart_top`. It receives 8N1 UART bytes on `rx` and assembles them little-endian into 32-bit words. It writes `CELL_NUMBERS` words into instruction memory starting at word address 0. When the last word is written it raises `load_done`, which the top level uses to release the CPU so execution starts from a fully loaded image.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `CELL_NUMBERS`, default 64: number of 32-bit words to load. Must be ≥ 1.
- `ADDR_W`, default 6: instruction-memory word-address width. Requires 2^ADDR_W ≥ `CELL_NUMBERS`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rx` input 1: UART serial line, asynchronous to `clk`, idles high.
- `imem_we` output 1: one-cycle write strobe to instruction memory.
- `imem_addr` output `ADDR_W`: word address of the current write.
- `imem_wdata` output 32: word being written.
- `load_done` output 1: high once all `CELL_NUMBERS` words are written. Sticky until reset.
- `frame_err` output 1: sticky flag, set when a stop bit is sampled low.

## Operation

- `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Bit-level receive FSM:
  - IDLE → START on a low synchronized `rx`.
  - START: wait `CLKS_PER_BIT/2` cycles, then resample. If `rx` is high, treat it as a glitch and return to IDLE. If low, go to DATA.
  - DATA: sample 8 bits, LSB first, each `CLKS_PER_BIT` cycles apart at mid-bit.
  - STOP: sample at mid-bit.
    - High: the byte is valid; go to IDLE.
    - Low: set `frame_err`, drop the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx` is high, then go to IDLE.
- Word assembler:
  - A valid byte goes into lane `lane` (0..3). Lane 0 is `wdata[7:0]`, lane 3 is `wdata[31:24]`.
  - A dropped byte does not advance `lane`.
  - On the lane-3 byte, pulse `imem_we` for exactly one cycle. At the same time, `imem_addr` = current word index and `imem_wdata` = the assembled word. Then `lane` returns to 0 and the word index increments.
- Completion:
  - After the write at index `CELL_NUMBERS-1`, `load_done` goes high and stays high.
  - Once `load_done` is high, all further bytes are ignored: no writes and no index change.
  - The receive FSM keeps running, and `frame_err` can still set.

## Timing

- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `load_done`=0, `frame_err`=0, lane=0, word index=0, FSM=IDLE.
- Reset acts immediately when asserted and discards any partial word.
- Latency: a start edge on `rx` is seen by the FSM 2 cycles later, because of the synchronizer.
- `imem_we` asserts on the cycle after the lane-3 stop-bit sample.
- `load_done` asserts on the cycle after the final `imem_we` pulse.
- `imem_addr`/`imem_wdata` hold their last written values between strobes.
- Bit counter is `$clog2(CLKS_PER_BIT)` bits wide and compares against `CLKS_PER_BIT-1`.
- Word index is `ADDR_W` bits. The `load_done` gate prevents it from wrapping.
- `CELL_NUMBERS`=1: `load_done` asserts after the first word is written.
- A low on `rx` shorter than `CLKS_PER_BIT/2` cycles produces no byte.

## Structure

- Shared package `loader_pkg`:
  - RX FSM state encoding: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Localparams for bits per byte (8) and bytes per word (4).
- Sub-module `uart_rx_byte`:
  - Contains the synchronizer, bit FSM and counters.
  - Outputs `byte_valid` (1-cycle pulse), `byte_data[7:0]` and `frame_err_pulse`.
- `uart_prog_loader` instantiates it and holds the lane/index logic and the write and done registers.

## Test plan

Bench parameters: `CLKS_PER_BIT`=4, `CELL_NUMBERS`=2, `ADDR_W`=1.

- Single word: send 0x13, 0x02, 0x50, 0x00 → exactly one `imem_we` pulse with `imem_addr`=0 and `imem_wdata`=0x00500213; `load_done`=0.
- Full load: send 8 bytes, 0x11..0x18 → writes at addr 0 (0x14131211) and addr 1 (0x18171615); `load_done`=1 one cycle after the second strobe. A 9th byte produces no `imem_we` and `load_done` stays 1.
- Glitch: drive `rx` low for 1 cycle, then high → no `byte_valid`, no write, `frame_err`=0.
- Framing error: send 0xAA with stop bit low → `frame_err`=1, byte dropped. Then 0x01, 0x02, 0x03, 0x04 → write addr 0, data 0x04030201.
- Reset mid-word: send 2 bytes, pulse `rst` low → all outputs 0 immediately. Then 0xDE, 0xAD, 0xBE, 0xEF → write addr 0, data 0xEFBEADDE.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: receive FSM states and
// byte/word geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling FSM.
// Emits a one-cycle byte_valid with the byte, or a one-cycle
// frame_err_pulse when the stop bit is sampled low.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT = 3'(BITS_PER_BYTE - 1);

  logic             rx_meta;
  logic             rx_sync;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Bring the asynchronous serial line into the clk domain; idle-high reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Bit-level receive FSM with registered byte/error strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      byte_valid      <= 1'b0;
      byte_data       <= '0;
      frame_err_pulse <= 1'b0;
    end else begin
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= START;
        end
        START: begin
          // Half a bit in: a real start bit is still low, a glitch is not
          if (cnt == HALF_CNT) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_idx == LAST_BIT) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
              state      <= IDLE;
            end else begin
              frame_err_pulse <= 1'b1;
              state           <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A stuck-low line must return high before the next start bit counts
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: assembles received bytes little-endian into 32-bit
// words and writes CELL_NUMBERS of them to instruction memory from address 0,
// then raises a sticky load_done that releases the CPU.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int CELL_NUMBERS = 64,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_NUMBERS - 1);
  localparam logic [1:0]        LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err_pulse;
  logic              accept;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] word_idx;
  logic [23:0]       lane_word;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .frame_err_pulse(frame_err_pulse)
  );

  // Bytes arriving after the image is complete are ignored entirely
  assign accept = byte_valid && !load_done;

  // One holding register per lower lane; the top lane goes straight to the write
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
      logic [7:0] held;

      // Capture the byte addressed to this lane
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) held <= '0;
        else if (accept && lane == 2'(gi)) held <= byte_data;
      end

      assign lane_word[gi*8 +: 8] = held;
    end
  endgenerate

  // Lane/index bookkeeping and the memory write strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane       <= '0;
      word_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        if (lane == LAST_LANE) begin
          imem_we    <= 1'b1;
          imem_addr  <= word_idx;
          imem_wdata <= {byte_data, lane_word};
          lane       <= '0;
          word_idx   <= word_idx + ADDR_W'(1);
        end else begin
          lane <= lane + 2'd1;
        end
      end
    end
  end

  // Completion goes high the cycle after the final write and stays high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) load_done <= 1'b0;
    else if (imem_we && imem_addr == LAST_ADDR) load_done <= 1'b1;
  end

  // Sticky framing-error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_err <= 1'b0;
    else if (frame_err_pulse) frame_err <= 1'b1;
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares them as the DUT strobes imem_we.
module tb_uart_prog_loader;

  localparam int CPB   = 4;
  localparam int CELLS = 2;
  localparam int AW    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          load_done;
  logic          frame_err;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .CELL_NUMBERS(CELLS),
    .ADDR_W      (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .load_done (load_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected memory writes
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  // Reference model: bytes of the current word, words written, flags
  logic [7:0] m_bytes[$];
  int         m_idx;
  bit         m_done;
  bit         m_ferr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_idx  = 0;
    m_done = 0;
    m_ferr = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [31:0] w;
    if (!stop_ok) begin
      m_ferr = 1;
    end else if (!m_done) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        exp_addr_q.push_back(m_idx);
        exp_data_q.push_back(w);
        m_bytes.delete();
        m_idx++;
        if (m_idx == CELLS) m_done = 1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    $display("tx byte 0x%02h stop_ok=%0d", b, stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_glitch();
    $display("tx glitch");
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_rst_we"},    32'(imem_we),    32'h0);
    check({tag, "_rst_addr"},  32'(imem_addr),  32'h0);
    check({tag, "_rst_wdata"}, imem_wdata,      32'h0);
    check({tag, "_rst_done"},  32'(load_done),  32'h0);
    check({tag, "_rst_ferr"},  32'(frame_err),  32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    repeat (12) @(negedge clk);
    #1;
    check({tag, "_pending"},   32'(exp_addr_q.size()), 32'h0);
    check({tag, "_load_done"}, 32'(load_done),         32'(m_done));
    check({tag, "_frame_err"}, 32'(frame_err),         32'(m_ferr));
  endtask

  // Monitor: compare each write against the scoreboard and track load_done
  bit mon_done;
  bit mon_pend;
  always @(negedge clk) begin
    if (!rst) begin
      mon_done = 0;
      mon_pend = 0;
    end else begin
      if (mon_pend) mon_done = 1;
      mon_pend = 0;
      if (load_done !== mon_done) check("load_done_timing", 32'(load_done), 32'(mon_done));
      if (imem_we) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", 32'(imem_we), 32'h0);
        end else begin
          int          ea;
          logic [31:0] ed;
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          $display("write addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)",
                   imem_addr, imem_wdata, ea, ed);
          check("write_addr", 32'(imem_addr), 32'(ea));
          check("write_data", imem_wdata, ed);
          if (ea == CELLS - 1) mon_pend = 1;
        end
      end
    end
  end

  initial begin
    logic [7:0] seq[$];

    model_reset();
    #1;
    check("init_we",    32'(imem_we),   32'h0);
    check("init_addr",  32'(imem_addr), 32'h0);
    check("init_wdata", imem_wdata,     32'h0);
    check("init_done",  32'(load_done), 32'h0);
    check("init_ferr",  32'(frame_err), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single word
    seq = '{8'h13, 8'h02, 8'h50, 8'h00};
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    check_state("single");

    // Full load, then one extra byte that must be ignored
    do_reset("full");
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i), 1'b1);
    check_state("full");
    send_byte(8'h19, 1'b1);
    check_state("extra");

    // Glitch, then framing error, then a clean word at address 0
    do_reset("glitch");
    send_glitch();
    check_state("glitch");
    send_byte(8'hAA, 1'b0);
    check_state("ferr");
    seq = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    check_state("after_ferr");

    // Reset mid-word discards the partial word
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    do_reset("midword");
    seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (seq[i]) send_byte(seq[i], 1'b1);
    check_state("midword");

    // Randomized traffic with occasional glitches and framing errors
    for (int it = 0; it < 4; it++) begin
      int n;
      do_reset("rand");
      n = $urandom_range(3, 11);
      for (int k = 0; k < n; k++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) send_glitch();
        else send_byte(8'($urandom), r != 1);
      end
      check_state("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
